// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU front end and control unit.
//   - Opcode encodings OP_NOP..OP_SHR (4'b0000..4'b1000); anything above
//     OP_LAST_DEFINED is an undefined opcode.
//   - Bit positions of the instruction fields: opcode[7:4], rd[3:2], rs[1:0].
//   - is_defined_op(): true when an opcode lies in the defined range.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;

    localparam logic [3:0] OP_LAST_DEFINED = OP_SHR;

    localparam int INSTR_W    = 8;
    localparam int OPCODE_MSB = 7;
    localparam int OPCODE_LSB = 4;
    localparam int RD_MSB     = 3;
    localparam int RD_LSB     = 2;
    localparam int RS_MSB     = 1;
    localparam int RS_LSB     = 0;

    function automatic logic is_defined_op(input logic [3:0] op);
        return (op <= OP_LAST_DEFINED);
    endfunction

endpackage

// File: rtl/fetch_decode_unit_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Program counter register. A load takes priority over an increment; the
// increment wraps modulo 2^PC_W.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pc <= RESET_PC)
//   load         write load_val into the PC this cycle
//   load_val     PC_W-bit load target
//   inc          advance the PC by one (ignored when load=1)
//   pc           current PC
// ---------------------------------------------------------------------------
module pc_reg #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_ONE;
        end
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// fetch_decode_unit
// Instruction fetch and field decode stage. Fetches one byte per
// instruction over a req/ack memory port, splits it into opcode/rd/rs and
// hands it downstream over a valid/ready handshake. Handles PC redirects and
// screens undefined opcodes (4'b1001..4'b1111): these set the sticky
// illegal_op flag and issue as NOP with rd/rs passed through.
//
// Optional feature (macro HALT_ON_ILLEGAL_EN): an undefined opcode sends the
// FSM to HALT instead of issuing; only reset leaves HALT.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              run permission (sampled in IDLE and at issue)
//   imem_req/imem_addr  fetch request and address (address = PC)
//   imem_ack/imem_data  memory response, data valid with ack
//   pc_load/pc_load_val one-cycle redirect strobe and target
//   issue_valid/ready   downstream handshake
//   opcode, rd, rs      decoded fields of the issued instruction
//   pc_out              address of the issued instruction
//   illegal_op          sticky: undefined opcode seen since reset
// ---------------------------------------------------------------------------
module fetch_decode_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_load_val,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [3:0]      opcode,
    output logic [1:0]      rd,
    output logic [1:0]      rs,
    output logic [PC_W-1:0] pc_out,
    output logic            illegal_op
);

    import cpu_pkg::*;

`ifdef HALT_ON_ILLEGAL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_ISSUE, ST_HALT} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_ISSUE} state_t;
`endif

    state_t          state, state_next;
    logic [PC_W-1:0] pc;
    logic            pc_ld;
    logic            pc_inc;
    logic [PC_W-1:0] pc_ld_val;
    logic            capture;
    logic            redirect_pending;
    logic [PC_W-1:0] redirect_target;
    logic [3:0]      instr_op;

    assign instr_op    = imem_data[OPCODE_MSB:OPCODE_LSB];
    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = pc;
    assign issue_valid = (state == ST_ISSUE);

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_ld),
        .load_val (pc_ld_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_ld_val  = pc_load_val;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                pc_ld = pc_load;
                if (enable) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (redirect_pending || pc_load) begin
                        // Redirect won the race with this fetch: drop the
                        // returned byte and re-request from the target. A
                        // same-cycle strobe is the most recent target.
                        pc_ld     = 1'b1;
                        pc_ld_val = pc_load ? pc_load_val : redirect_target;
                    end else begin
                        capture = 1'b1;
                        pc_inc  = 1'b1;
`ifdef HALT_ON_ILLEGAL_EN
                        state_next = is_defined_op(instr_op) ? ST_ISSUE : ST_HALT;
`else
                        state_next = ST_ISSUE;
`endif
                    end
                end
            end
            ST_ISSUE: begin
                // With ready the instruction issues and the redirect only
                // retargets the next fetch; without ready it is flushed.
                pc_ld = pc_load;
                if (issue_ready) begin
                    state_next = enable ? ST_FETCH : ST_IDLE;
                end else if (pc_load) begin
                    state_next = ST_FETCH;
                end
            end
`ifdef HALT_ON_ILLEGAL_EN
            ST_HALT: state_next = ST_HALT;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // A redirect seen mid-fetch is held until the outstanding ack arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pending <= 1'b0;
            redirect_target  <= RESET_PC;
        end else if (state == ST_FETCH) begin
            if (imem_ack) begin
                redirect_pending <= 1'b0;
            end else if (pc_load) begin
                redirect_pending <= 1'b1;
                redirect_target  <= pc_load_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode     <= OP_NOP;
            rd         <= '0;
            rs         <= '0;
            pc_out     <= RESET_PC;
            illegal_op <= 1'b0;
        end else if (capture) begin
            opcode <= is_defined_op(instr_op) ? instr_op : OP_NOP;
            rd     <= imem_data[RD_MSB:RD_LSB];
            rs     <= imem_data[RS_MSB:RS_LSB];
            pc_out <= pc;
            if (!is_defined_op(instr_op)) illegal_op <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_unit
// Directed checks for latency, stalls, undefined opcodes, redirects, PC wrap
// and asynchronous reset, followed by a randomized run. The stimulus process
// plays the memory and downstream roles and keeps an instruction-stream
// model (next address, pending redirect, sticky illegal flag); each fetch it
// expects to issue is queued, and a separate monitor compares every
// presented instruction against the queue head.
// ---------------------------------------------------------------------------
module tb_fetch_decode_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic       issue_valid;
    logic       issue_ready;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] pc_out;
    logic       illegal_op;

    always #5 clk = ~clk;

    fetch_decode_unit #(
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .opcode      (opcode),
        .rd          (rd),
        .rs          (rs),
        .pc_out      (pc_out),
        .illegal_op  (illegal_op)
    );

    typedef struct {
        logic [7:0] pc;
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       ill;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem [256];
    int         checks = 0;
    int         errors = 0;

    // Instruction-stream model
    logic [7:0] model_pc;
    logic       m_pending;
    logic [7:0] m_target;
    logic       m_illegal;

    // Stimulus knobs
    int         wait_left  = -1;
    int         fixed_wait = 0;
    int         wait_max   = 0;
    int         ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
    logic       rand_load  = 1'b0;
    logic       load_req   = 1'b0;
    logic [7:0] load_req_val = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decide this cycle's inputs from the visible handshake state and
    // advance the model accordingly.
    task automatic drive_cycle();
        logic       ack;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] instr;
        exp_t       e;
        ack = 1'b0;
        if (imem_req) begin
            if (wait_left < 0)
                wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, wait_max));
            if (wait_left == 0) begin
                ack = 1'b1;
                wait_left = -1;
            end else begin
                wait_left--;
            end
        end else begin
            wait_left = -1;
        end
        ld = 1'b0;
        lv = 8'($urandom_range(0, 255));
        if (load_req) begin
            ld = 1'b1;
            lv = load_req_val;
            load_req = 1'b0;
        end else if (rand_load && $urandom_range(0, 9) == 0) begin
            ld = 1'b1;
        end
        case (ready_mode)
            0:       issue_ready = 1'($urandom_range(0, 1));
            1:       issue_ready = 1'b1;
            default: issue_ready = 1'b0;
        endcase
        imem_ack    = ack;
        imem_data   = ack ? mem[imem_addr] : 8'($urandom_range(0, 255));
        pc_load     = ld;
        pc_load_val = lv;

        if (ack) begin
            check("fetch_addr", {24'h0, imem_addr}, {24'h0, model_pc});
            if (ld || m_pending) begin
                model_pc  = ld ? lv : m_target;
                m_pending = 1'b0;
            end else begin
                instr  = mem[model_pc];
                e.pc   = model_pc;
                e.rd   = instr[3:2];
                e.rs   = instr[1:0];
                if (instr[7:4] >= 4'd9) begin
                    e.op      = 4'd0;
                    m_illegal = 1'b1;
                end else begin
                    e.op = instr[7:4];
                end
                e.ill = m_illegal;
                exp_q.push_back(e);
                model_pc = model_pc + 8'd1;
            end
        end else if (ld) begin
            if (imem_req) begin
                m_pending = 1'b1;
                m_target  = lv;
            end else begin
                model_pc = lv;
            end
        end
    endtask

    task automatic tick();
        drive_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pc  = 8'h00;
        m_pending = 1'b0;
        m_target  = 8'h00;
        m_illegal = 1'b0;
        wait_left = -1;
    endtask

    // Monitor: compare each presented instruction with the expected head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && issue_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: got pc_out=%0h opcode=%0h expected no issue (t=%0t)",
                             pc_out, opcode, $time);
                end else begin
                    e = exp_q[0];
                    check("issue_fields", {15'h0, pc_out, opcode, rd, rs, illegal_op},
                          {15'h0, e.pc, e.op, e.rd, e.rs, e.ill});
                    if (issue_ready || pc_load) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'h1E;
        mem[1] = 8'h5A;
        mem[2] = 8'hC4;
        mem[3] = 8'h27;
        mem[8'h40] = 8'h36;
        mem[8'hFF] = 8'h81;
        model_reset();

        rst_n = 1'b0; enable = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;
        pc_load = 1'b0; pc_load_val = 8'h00; issue_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",     {31'h0, imem_req},    32'h0);
        check("rst_addr",    {24'h0, imem_addr},   32'h0);
        check("rst_valid",   {31'h0, issue_valid}, 32'h0);
        check("rst_fields",  {24'h0, opcode, rd, rs}, 32'h0);
        check("rst_pc_out",  {24'h0, pc_out},      32'h0);
        check("rst_illegal", {31'h0, illegal_op},  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency from IDLE with zero-wait memory
        enable = 1'b1; fixed_wait = 0; ready_mode = 1;
        tick();
        check("c1_req",  {31'h0, imem_req},  32'h1);
        check("c1_addr", {24'h0, imem_addr}, 32'h0);
        tick();
        check("c2_valid",  {31'h0, issue_valid}, 32'h1);
        check("c2_fields", {24'h0, opcode, rd, rs}, {24'h0, 4'b0001, 2'b11, 2'b10});
        check("c2_pc_out", {24'h0, pc_out}, 32'h0);
        tick();
        check("c3_addr", {24'h0, imem_addr}, 32'h1);
        tick();

        // Three-cycle downstream stall
        ready_mode = 2;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid",  {31'h0, issue_valid}, 32'h1);
            check("stall_fields", {24'h0, opcode, rd, rs}, {24'h0, 4'b0101, 2'b10, 2'b10});
            check("stall_no_req", {31'h0, imem_req}, 32'h0);
            tick();
        end
        ready_mode = 1;
        check("stall_end_valid", {31'h0, issue_valid}, 32'h1);
        tick();

        // Undefined opcode 8'hC4
        check("c4_addr", {24'h0, imem_addr}, 32'h2);
        tick();
        check("c4_fields",  {24'h0, opcode, rd, rs}, {24'h0, 4'b0000, 2'b01, 2'b00});
        check("c4_illegal", {31'h0, illegal_op}, 32'h1);
        tick();
        tick();
        check("legal_after_illegal_op", {28'h0, opcode}, 32'h2);
        check("illegal_sticky", {31'h0, illegal_op}, 32'h1);

        // Redirect in FETCH, ack two cycles later
        fixed_wait = 2;
        tick();
        check("redir_fetch_start", {31'h0, imem_req}, 32'h1);
        load_req = 1'b1; load_req_val = 8'h40;
        tick();
        tick();
        tick();
        check("redir_no_issue", {31'h0, issue_valid}, 32'h0);
        check("redir_req",      {31'h0, imem_req},    32'h1);
        check("redir_addr",     {24'h0, imem_addr},   32'h40);
        fixed_wait = 0;
        tick();
        check("redir_pc_out", {24'h0, pc_out}, 32'h40);

        // PC wrap: redirect to 8'hFF at issue, then fetch after FF
        load_req = 1'b1; load_req_val = 8'hFF;
        tick();
        check("wrap_ff_addr", {24'h0, imem_addr}, 32'hFF);
        tick();
        check("wrap_pc_out", {24'h0, pc_out}, 32'hFF);
        tick();
        check("wrap_00_addr", {24'h0, imem_addr}, 32'h00);

        // Asynchronous reset while a fetch is outstanding
        fixed_wait = 10;
        tick();
        tick();
        check("pre_rst_req", {31'h0, imem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req",     {31'h0, imem_req},   32'h0);
        check("async_rst_addr",    {24'h0, imem_addr},  32'h0);
        check("async_rst_illegal", {31'h0, illegal_op}, 32'h0);
        model_reset();
        enable = 1'b0; pc_load = 1'b0; issue_ready = 1'b1;
        imem_ack = 1'b1; imem_data = 8'h1E;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("late_ack_no_req",   {31'h0, imem_req},    32'h0);
            check("late_ack_no_issue", {31'h0, issue_valid}, 32'h0);
        end
        imem_ack = 1'b0;

        // Randomized run
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        enable = 1'b1; ready_mode = 0; fixed_wait = -1; wait_max = 3; rand_load = 1'b1;
        repeat (3000) tick();

        // Drain and stop
        rand_load = 1'b0; ready_mode = 1; enable = 1'b0;
        repeat (20) tick();
        check("drain_queue_empty", exp_q.size(), 32'h0);
        check("drain_idle_valid",  {31'h0, issue_valid}, 32'h0);
        check("drain_idle_req",    {31'h0, imem_req},    32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
